// File: rtl/spi_display_sink_if.sv
//------------------------------------------------------------------------------
// spi_display_if
// Bundle of the five SSD1306-style 4-wire SPI display link wires.
// Ports (signals):
//   video_rst  - display reset, active-low, asynchronous to the sink clock
//   video_cs   - chip select, active-low
//   video_dc   - 0 = command byte, 1 = data byte
//   video_sclk - SPI clock, mode 0
//   video_mosi - serial data, MSB first
// Modports: master drives the link (display driver), slave receives it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_display_if;
  logic video_rst;
  logic video_cs;
  logic video_dc;
  logic video_sclk;
  logic video_mosi;

  modport master (
    output video_rst,
    output video_cs,
    output video_dc,
    output video_sclk,
    output video_mosi
  );

  modport slave (
    input video_rst,
    input video_cs,
    input video_dc,
    input video_sclk,
    input video_mosi
  );
endinterface

`default_nettype wire

// File: rtl/spi_display_sink.sv
//------------------------------------------------------------------------------
// spi_display_sink
// Receive-side model of an SSD1306-style 4-wire SPI display link. Samples the
// link on clk, assembles bytes, decodes the command stream (including column
// and page address windows) and emits byte-wide framebuffer writes.
// Ports:
//   clk, rst_n       - system clock, synchronous active-low reset
//   video            - SPI link (slave modport)
//   fb_we/fb_col/fb_page/fb_data - one-cycle framebuffer write
//   cmd_valid/cmd_param/cmd_byte - one-cycle strobe per command-stream byte
//   display_on, contrast          - decoded display state
//   frame_done       - strobe on the write that wraps the whole window
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_display_sink #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  spi_display_if.slave                  video,
  output logic                          fb_we,
  output logic [$clog2(COLS)-1:0]       fb_col,
  output logic [$clog2(PAGES)-1:0]      fb_page,
  output logic [7:0]                    fb_data,
  output logic                          cmd_valid,
  output logic                          cmd_param,
  output logic [7:0]                    cmd_byte,
  output logic                          display_on,
  output logic [7:0]                    contrast,
  output logic                          frame_done
);

  localparam int COL_W  = $clog2(COLS);
  localparam int PAGE_W = $clog2(PAGES);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARAM1 = 2'd1,
    ST_PARAM2 = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers, packed {rst,cs,dc,sclk,mosi}.
  // The synced display reset starts asserted so the parser stays in reset
  // until a clean high level has propagated through the synchronizer.
  // ---------------------------------------------------------------------------
  logic [4:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 5'b01000;
      sync2 <= 5'b01000;
    end else begin
      sync1 <= {video.video_rst, video.video_cs, video.video_dc,
                video.video_sclk, video.video_mosi};
      sync2 <= sync1;
    end
  end

  logic rst_s, cs_s, dc_s, sclk_s, mosi_s;
  assign {rst_s, cs_s, dc_s, sclk_s, mosi_s} = sync2;

  // Protocol reset: either the system reset or the display reset line.
  logic proto_rst;
  assign proto_rst = !rst_n || !rst_s;

  // The edge register tracks sclk even during a display reset, so a link
  // released with sclk high cannot fake a rising edge.
  logic sclk_d;
  always_ff @(posedge clk) begin
    if (!rst_n) sclk_d <= 1'b0;
    else        sclk_d <= sclk_s;
  end

  logic sclk_rise;
  assign sclk_rise = sclk_s && !sclk_d;

  // ---------------------------------------------------------------------------
  // Bit assembly. Only the seven most recent bits need storing; the eighth
  // comes straight from the synchronizer when the byte completes.
  // ---------------------------------------------------------------------------
  logic [6:0] shreg;
  logic [2:0] bitcnt;
  logic       byte_rdy;
  logic [7:0] byte_val;
  logic       byte_dc;

  always_ff @(posedge clk) begin
    if (proto_rst) begin
      shreg    <= '0;
      bitcnt   <= '0;
      byte_rdy <= 1'b0;
      byte_val <= '0;
      byte_dc  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      if (cs_s) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else if (sclk_rise) begin
        shreg  <= {shreg[5:0], mosi_s};
        bitcnt <= bitcnt + 3'd1;      // wraps to 0 after the 8th bit
        if (bitcnt == 3'd7) begin
          byte_rdy <= 1'b1;
          byte_val <= {shreg, mosi_s};
          byte_dc  <= dc_s;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Parser FSM and write-pointer advance
  // ---------------------------------------------------------------------------
  state_t            state, state_next;
  logic [7:0]        opcode;
  logic [COL_W-1:0]  p1;
  logic [COL_W-1:0]  col_start, col_end, col_ptr, col_next;
  logic [PAGE_W-1:0] page_start, page_end, page_ptr, page_next;
  logic              wrap;
  logic              one_param_op;
  logic              disp_int;
  logic [7:0]        contrast_int;

  always_comb begin
    one_param_op = 1'b0;
    case (byte_val)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: one_param_op = 1'b1;
      default:                    one_param_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proto_rst) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (byte_rdy) begin
      if (byte_dc) begin
        // A data byte aborts any command in progress.
        state_next = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_val == 8'h21 || byte_val == 8'h22 || one_param_op)
              state_next = ST_PARAM1;
          end
          ST_PARAM1: begin
            state_next = (opcode == 8'h21 || opcode == 8'h22) ? ST_PARAM2 : ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Pointer advance: column first, then page; wrap back to the window start.
  // Windows with start > end simply count modulo until they reach end.
  always_comb begin
    col_next  = col_ptr;
    page_next = page_ptr;
    wrap      = 1'b0;
    if (col_ptr != col_end) begin
      col_next = col_ptr + 1'b1;
    end else begin
      col_next = col_start;
      if (page_ptr != page_end) begin
        page_next = page_ptr + 1'b1;
      end else begin
        page_next = page_start;
        wrap      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (proto_rst) begin
      fb_we        <= 1'b0;
      fb_col       <= '0;
      fb_page      <= '0;
      fb_data      <= '0;
      frame_done   <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_param    <= 1'b0;
      cmd_byte     <= '0;
      opcode       <= '0;
      p1           <= '0;
      col_start    <= '0;
      col_end      <= COL_LAST;
      col_ptr      <= '0;
      page_start   <= '0;
      page_end     <= PAGE_LAST;
      page_ptr     <= '0;
      disp_int     <= 1'b0;
      contrast_int <= 8'h7F;
      display_on   <= 1'b0;
      contrast     <= 8'h7F;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      cmd_valid  <= 1'b0;
      if (byte_rdy) begin
        if (byte_dc) begin
          fb_we      <= 1'b1;
          fb_col     <= col_ptr;
          fb_page    <= page_ptr;
          fb_data    <= byte_val;
          frame_done <= wrap;
          col_ptr    <= col_next;
          page_ptr   <= page_next;
        end else begin
          cmd_valid <= 1'b1;
          cmd_param <= (state != ST_IDLE);
          cmd_byte  <= byte_val;
          case (state)
            ST_IDLE: begin
              opcode <= byte_val;
              if (byte_val[7:1] == 7'h57)   // 0xAE / 0xAF
                disp_int <= byte_val[0];
            end
            ST_PARAM1: begin
              p1 <= byte_val[COL_W-1:0];
              if (opcode == 8'h81)
                contrast_int <= byte_val;
            end
            ST_PARAM2: begin
              if (opcode == 8'h21) begin
                col_start <= p1;
                col_end   <= byte_val[COL_W-1:0];
                col_ptr   <= p1;
              end else begin
                page_start <= p1[PAGE_W-1:0];
                page_end   <= byte_val[PAGE_W-1:0];
                page_ptr   <= p1[PAGE_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end
      // Visible state trails the internal copy by one cycle, so the effect
      // appears in the cycle after the completing byte's cmd_valid.
      display_on <= disp_int;
      contrast   <= contrast_int;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_display_sink.sv
//------------------------------------------------------------------------------
// tb_spi_display_sink
// Directed self-checking bench for spi_display_sink.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_display_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fb_we, cmd_valid, cmd_param, display_on, frame_done;
  logic [6:0] fb_col;
  logic [2:0] fb_page;
  logic [7:0] fb_data, cmd_byte, contrast;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = 0;

  typedef struct {
    logic [6:0] col;
    logic [2:0] page;
    logic [7:0] data;
    logic       fd;
    int         cyc;
  } wr_t;

  typedef struct {
    logic       param;
    logic [7:0] b;
  } cmd_t;

  wr_t  wq[$];
  cmd_t cq[$];

  spi_display_if vif();

  spi_display_sink #(.COLS(128), .PAGES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .video      (vif),
    .fb_we      (fb_we),
    .fb_col     (fb_col),
    .fb_page    (fb_page),
    .fb_data    (fb_data),
    .cmd_valid  (cmd_valid),
    .cmd_param  (cmd_param),
    .cmd_byte   (cmd_byte),
    .display_on (display_on),
    .contrast   (contrast),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we)     wq.push_back('{fb_col, fb_page, fb_data, frame_done, cyc});
    if (cmd_valid) cq.push_back('{cmd_param, cmd_byte});
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vif.video_rst  = 1'b1;
    vif.video_cs   = 1'b1;
    vif.video_dc   = 1'b0;
    vif.video_sclk = 1'b0;
    vif.video_mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wq.delete();
    cq.delete();
  endtask

  task automatic send_bit(input logic b);
    vif.video_mosi = b;
    repeat (3) @(negedge clk);
    vif.video_sclk = 1'b1;
    rise_cyc = cyc;
    repeat (3) @(negedge clk);
    vif.video_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    vif.video_dc = dc;
    if (vif.video_cs) begin
      vif.video_cs = 1'b0;
      repeat (3) @(negedge clk);
    end
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (fb_we !== 1'b0)      begin n_fail++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
    n_cmp++; if (cmd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_cmp++; if ({fb_col, fb_page, fb_data, cmd_byte} !== 26'd0)
      begin n_fail++; $display("FAIL reset_fields got col=%0d page=%0d data=%h cmd=%h want zeros", fb_col, fb_page, fb_data, cmd_byte); end
    n_cmp++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL reset_display_on got %b want 0", display_on); end
    n_cmp++; if (contrast !== 8'h7F)  begin n_fail++; $display("FAIL reset_contrast got %h want 7f", contrast); end
  endtask

  task automatic test_single_write();
    apply_reset();
    send_byte(1'b1, 8'hA5);
    settle();
    n_cmp++;
    if (wq.size() !== 1) begin
      n_fail++; $display("FAIL single_count got %0d want 1", wq.size());
    end else begin
      n_cmp++;
      if (wq[0].col !== 7'd0 || wq[0].page !== 3'd0 || wq[0].data !== 8'hA5 || wq[0].fd !== 1'b0) begin
        n_fail++; $display("FAIL single_write got (%0d,%0d,%h,fd=%b) want (0,0,a5,fd=0)", wq[0].col, wq[0].page, wq[0].data, wq[0].fd);
      end
      n_cmp++;
      if (wq[0].cyc !== rise_cyc + 4) begin
        n_fail++; $display("FAIL latency got %0d want %0d", wq[0].cyc - rise_cyc, 4);
      end
    end
    n_cmp++; if (cq.size() !== 0) begin n_fail++; $display("FAIL single_no_cmd got %0d want 0", cq.size()); end
    wq.delete();
    send_byte(1'b1, 8'h5A);
    settle();
    n_cmp++;
    if (wq.size() !== 1 || wq[0].col !== 7'd1 || wq[0].page !== 3'd0 || wq[0].data !== 8'h5A) begin
      n_fail++; $display("FAIL single_advance got n=%0d col=%0d page=%0d want n=1 col=1 page=0", wq.size(), (wq.size() > 0) ? wq[0].col : 7'd0, (wq.size() > 0) ? wq[0].page : 3'd0);
    end
  endtask

  task automatic test_window();
    logic [7:0] cmds [6] = '{8'h21, 8'h10, 8'h11, 8'h22, 8'h02, 8'h03};
    logic       pars [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0] ecol [5] = '{7'd16, 7'd17, 7'd16, 7'd17, 7'd16};
    logic [2:0] epg  [5] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
    logic       efd  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int errs;
    apply_reset();
    for (int i = 0; i < 6; i++) send_byte(1'b0, cmds[i]);
    for (int i = 0; i < 5; i++) send_byte(1'b1, 8'(8'h40 + i));
    settle();
    n_cmp++;
    if (cq.size() !== 6) begin
      n_fail++; $display("FAIL window_cmd_count got %0d want 6", cq.size());
    end else begin
      errs = 0;
      for (int i = 0; i < 6; i++) if (cq[i].param !== pars[i] || cq[i].b !== cmds[i]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL window_cmd_seq got %0d bad entries want 0", errs); end
    end
    n_cmp++;
    if (wq.size() !== 5) begin
      n_fail++; $display("FAIL window_wr_count got %0d want 5", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (wq[i].col !== ecol[i] || wq[i].page !== epg[i] || wq[i].fd !== efd[i] || wq[i].data !== 8'(8'h40 + i)) begin
          n_fail++; $display("FAIL window_wr%0d got (%0d,%0d,fd=%b) want (%0d,%0d,fd=%b)", i, wq[i].col, wq[i].page, wq[i].fd, ecol[i], epg[i], efd[i]);
        end
      end
    end
  endtask

  task automatic test_degenerate();
    logic [6:0] ecol [5] = '{7'd126, 7'd127, 7'd0, 7'd1, 7'd126};
    logic [2:0] epg  [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    int errs;
    apply_reset();
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h7E); send_byte(1'b0, 8'h01);
    for (int i = 0; i < 5; i++) send_byte(1'b1, 8'(i));
    settle();
    errs = 0;
    if (wq.size() != 5) errs = 99;
    else for (int i = 0; i < 5; i++) if (wq[i].col !== ecol[i] || wq[i].page !== epg[i] || wq[i].fd !== 1'b0) errs++;
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL degenerate got %0d errors (n=%0d) want 0", errs, wq.size()); end
  endtask

  task automatic test_display_cmds();
    apply_reset();
    send_byte(1'b0, 8'hAF); settle();
    n_cmp++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL display_on_af got %b want 1", display_on); end
    send_byte(1'b0, 8'h81); send_byte(1'b0, 8'h30); settle();
    n_cmp++; if (contrast !== 8'h30) begin n_fail++; $display("FAIL contrast got %h want 30", contrast); end
    n_cmp++;
    if (cq.size() !== 3 || cq[1].param !== 1'b0 || cq[2].param !== 1'b1) begin
      n_fail++; $display("FAIL contrast_params got n=%0d want 3 entries with param 0,0,1", cq.size());
    end
    send_byte(1'b0, 8'hAE); settle();
    n_cmp++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL display_on_ae got %b want 0", display_on); end
    n_cmp++; if (wq.size() !== 0) begin n_fail++; $display("FAIL display_no_writes got %0d want 0", wq.size()); end
  endtask

  task automatic test_full_window();
    int errs, fds;
    apply_reset();
    for (int i = 0; i < 1024; i++) send_byte(1'b1, 8'(i * 7));
    settle();
    n_cmp++;
    if (wq.size() !== 1024) begin
      n_fail++; $display("FAIL full_count got %0d want 1024", wq.size());
    end else begin
      errs = 0; fds = 0;
      for (int i = 0; i < 1024; i++) begin
        if (wq[i].col !== 7'(i % 128) || wq[i].page !== 3'(i / 128) || wq[i].data !== 8'(i * 7)) errs++;
        if (wq[i].fd === 1'b1) fds++;
      end
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL full_order got %0d bad writes want 0", errs); end
      n_cmp++;
      if (fds != 1 || wq[1023].fd !== 1'b1) begin
        n_fail++; $display("FAIL full_frame_done got %0d pulses (last=%b) want 1 on last", fds, wq[1023].fd);
      end
    end
    wq.delete();
    send_byte(1'b1, 8'hEE); settle();
    n_cmp++;
    if (wq.size() !== 1 || wq[0].col !== 7'd0 || wq[0].page !== 3'd0) begin
      n_fail++; $display("FAIL full_wrap_ptr got n=%0d want 1 write at (0,0)", wq.size());
    end
  endtask

  task automatic test_cs_abort();
    apply_reset();
    vif.video_dc = 1'b1;
    vif.video_cs = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    vif.video_cs = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(1'b1, 8'h3C);
    settle();
    n_cmp++;
    if (wq.size() !== 1 || wq[0].data !== 8'h3C || wq[0].col !== 7'd0) begin
      n_fail++; $display("FAIL cs_abort got n=%0d data=%h want 1 write of 3c at col 0", wq.size(), (wq.size() > 0) ? wq[0].data : 8'h00);
    end
  endtask

  task automatic test_video_rst();
    apply_reset();
    send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h02); send_byte(1'b1, 8'h03);
    send_byte(1'b0, 8'hAF); settle();
    n_cmp++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL vrst_pre_on got %b want 1", display_on); end
    wq.delete(); cq.delete();
    vif.video_dc = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    vif.video_rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (display_on !== 1'b0) begin n_fail++; $display("FAIL vrst_display_on got %b want 0", display_on); end
    vif.video_rst = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wq.size() !== 0 || cq.size() !== 0) begin
      n_fail++; $display("FAIL vrst_spurious got wr=%0d cmd=%0d want 0 0", wq.size(), cq.size());
    end
    send_byte(1'b1, 8'h42); settle();
    n_cmp++;
    if (wq.size() !== 1 || wq[0].col !== 7'd0 || wq[0].page !== 3'd0 || wq[0].data !== 8'h42) begin
      n_fail++; $display("FAIL vrst_ptr got n=%0d col=%0d want 1 write of 42 at (0,0)", wq.size(), (wq.size() > 0) ? wq[0].col : 7'd0);
    end
  endtask

  task automatic test_cmd_abort();
    logic [6:0] ecol [3] = '{7'd2, 7'd3, 7'd2};
    logic [2:0] epg  [3] = '{3'd0, 3'd0, 3'd1};
    logic [7:0] edat [3] = '{8'h77, 8'h88, 8'h99};
    int errs;
    apply_reset();
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h02); send_byte(1'b0, 8'h03);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h05);
    send_byte(1'b1, 8'h77); send_byte(1'b1, 8'h88); send_byte(1'b1, 8'h99);
    settle();
    errs = 0;
    if (wq.size() != 3) errs = 99;
    else for (int i = 0; i < 3; i++) if (wq[i].col !== ecol[i] || wq[i].page !== epg[i] || wq[i].data !== edat[i]) errs++;
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL cmd_abort_writes got %0d errors (n=%0d) want 0", errs, wq.size()); end
    send_byte(1'b0, 8'hAF); settle();
    n_cmp++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL cmd_abort_idle got display_on=%b want 1", display_on); end
    n_cmp++;
    if (cq.size() !== 6 || cq[5].param !== 1'b0) begin
      n_fail++; $display("FAIL cmd_abort_opcode got n=%0d want 6 with last as opcode", cq.size());
    end
  endtask

  initial begin
    vif.video_rst  = 1'b1;
    vif.video_cs   = 1'b1;
    vif.video_dc   = 1'b0;
    vif.video_sclk = 1'b0;
    vif.video_mosi = 1'b0;
    test_reset();
    test_single_write();
    test_window();
    test_degenerate();
    test_display_cmds();
    test_cs_abort();
    test_video_rst();
    test_cmd_abort();
    test_full_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_display_sink.md
# spi_display_sink

Receive-side model of the SSD1306-style 4-wire SPI display link. It samples `video_rst`/`video_cs`/`video_dc`/`video_sclk`/`video_mosi` on the system clock, assembles bytes and decodes the command stream, including the column and page address windows. It emits byte-wide framebuffer writes (one column × 8 vertical pixels per data byte). It sits opposite the display driver as a loopback and verification sink, and can feed a capture framebuffer or a second panel model.

## Interface
Parameters:
- `COLS`, 128: panel width; column pointer width is 7 bits.
- `PAGES`, 8: panel height / 8; page pointer width is 3 bits.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `video_rst` in 1: display reset, active-low, asynchronous to `clk`.
- `video_cs` in 1: chip select, active-low.
- `video_dc` in 1: 0 = command byte, 1 = data byte.
- `video_sclk` in 1: SPI clock, mode 0 (idle low, sample on rising edge).
- `video_mosi` in 1: serial data, MSB first.
- `fb_we` out 1: one-cycle framebuffer write strobe.
- `fb_col` out 7: column of the write.
- `fb_page` out 3: page of the write.
- `fb_data` out 8: pixel byte. Bit n = row `fb_page*8+n`.
- `cmd_valid` out 1: one-cycle strobe for each byte received with dc=0.
- `cmd_param` out 1: qualifies `cmd_valid`; 1 = parameter byte, 0 = opcode.
- `cmd_byte` out 8: command or parameter byte.
- `display_on` out 1: 1 after 0xAF, 0 after 0xAE.
- `contrast` out 8: last parameter of 0x81.
- `frame_done` out 1: one-cycle strobe when the write pointer wraps the full window.

## Operation
- **Input conditioning.** All five inputs pass through 2-flop synchronizers. A registered copy of synced sclk drives rising-edge detection.
- **Bit assembly.** On each detected sclk rise with synced cs=0:
  - shift mosi into an 8-bit register, MSB first;
  - increment the 3-bit bit counter.
  - On the 8th bit, latch the byte together with synced dc at that same edge, and clear the counter.
- **cs handling.** synced cs=1 clears the bit counter and discards any partial byte. Parser state persists across cs toggles.
- **Display reset.** synced `video_rst`=0 acts as a protocol reset: all parser state returns to reset values, and the outputs do as well. `rst_n` does the same.
- **Parser FSM**, states IDLE, PARAM1, PARAM2. Applies to dc=0 bytes.
  - IDLE, 0x21 or 0x22: store opcode, go to PARAM1.
  - IDLE, 0x20/0x81/0x8D/0xA8/0xD3/0xD5/0xD9/0xDA/0xDB: go to PARAM1; these take 1 parameter.
  - IDLE, 0xAE/0xAF: set `display_on` to bit 0. Stay in IDLE.
  - IDLE, any other opcode: no parameters; stay in IDLE.
  - PARAM1, 1-parameter opcode: apply (0x81 sets `contrast`; the others are ignored), go to IDLE.
  - PARAM1, 0x21/0x22: hold the parameter as start, go to PARAM2.
  - PARAM2, 0x21: `col_start` = p1[6:0], `col_end` = p2[6:0], col pointer = `col_start`. Go to IDLE.
  - PARAM2, 0x22: `page_start` = p1[2:0], `page_end` = p2[2:0], page pointer = `page_start`. Go to IDLE.
- **Data bytes during a command.** A dc=1 byte arriving while in PARAM1/PARAM2 aborts the command to IDLE; the data byte is still written.
- **Data write.** For each dc=1 byte, emit `fb_we` at (col, page), then advance the pointer:
  - if col≠`col_end`: col+1, with 7-bit wrap;
  - else col=`col_start`, and then if page≠`page_end`: page+1, else page=`page_start` and pulse `frame_done` in the same cycle as this `fb_we`.
- **Degenerate windows.** start > end is legal: the pointer increments with modular wrap until it equals end.
- **Reset values.**
  - Outputs: all strobes 0, `fb_col`/`fb_page`/`fb_data`/`cmd_byte` 0, `display_on` 0, `contrast` 0x7F.
  - Internal: window 0..127 / 0..7, pointers 0, FSM IDLE, bit counter 0.

## Timing
- **Latency.** `fb_we`/`cmd_valid` go high on the 4th `clk` rising edge after the raw 8th sclk rising edge: 2 synchronizer stages, 1 edge register, 1 output register. `fb_col`/`fb_page`/`fb_data` are valid in the same cycle.
- **Register updates.** Register effects (`display_on`, `contrast`, window, pointers) are visible in the cycle after the `cmd_valid` of the completing byte.
- **Input constraints.**
  - sclk high and low times ≥ 3 `clk` each.
  - mosi/dc stable ≥ 3 `clk` before the sclk rise.
  - cs falls ≥ 3 `clk` before the first sclk rise.
  - Violations are not detected.
- **Throughput.** One byte per 48 `clk` minimum; the block adds no back-pressure.
- **rst_n sampling.** `rst_n` is sampled on `clk` only. A reset mid-byte discards the byte, and no strobe issues.

## Test plan
- Reset, then cs low, dc=1, byte 0xA5 → exactly one `fb_we` with col 0, page 0, data 0xA5. Pointer advances to col 1, page 0.
- 0x21,0x10,0x11 then 0x22,0x02,0x03, then 5 data bytes → writes at (16,2),(17,2),(16,3),(17,3), with `frame_done` on the 4th write; the 5th write lands at (16,2). `cmd_valid` fires 6 times, with `cmd_param`=0,1,1,0,1,1.
- 0xAF → `display_on`=1. Then 0x81,0x30 → `contrast`=0x30. Then 0xAE → `display_on`=0.
- Full window: 1024 data bytes → writes cover every (col,page) exactly once; `frame_done` fires on the write at (127,7) only; pointer returns to (0,0).
- cs raised after 5 bits, then a full byte 0x3C → only 0x3C is received. In a second run, assert `video_rst` low mid-frame → pointer resets to (0,0), `display_on`=0, no spurious strobe.
- 0x21,0x05 then dc=1 byte 0x77 → FSM aborts to IDLE, write at the prior pointer with data 0x77, and the column window is unchanged.
